// File: rtl/sdram_arbiter_pkg.sv
// Shared SDRAM definitions: controller command opcodes, transaction owners and
// arbiter FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package sdram_arbiter_pkg;

  // Encoding driven on MEM_OP toward the SDRAM controller.
  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_REFRESH = 2'b10
  } mem_op_e;

  // Who owns the single outstanding transaction.
  typedef enum logic [1:0] {
    OWN_VID = 2'd0,
    OWN_CPU = 2'd1,
    OWN_REF = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval timer with a sticky pending flag.
// Latency: o_req rises on the terminal count cycle, REFRESH_CYCLES cycles after reset release.
// Backpressure: pending is held (never queued) until i_clr; further wraps merge into it.
// Ports: i_clk/i_rst_n clock and async active-low reset, i_clr clears the pending
//        flag (refresh accepted), o_req = refresh wanted.
module sdram_refresh_timer #(
  parameter int REFRESH_CYCLES = 390
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_req
);

  localparam int CNT_W = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_pending;
  logic             w_tick;

  assign w_tick = (r_cnt == CNT_W'(REFRESH_CYCLES - 1));

  // The terminal count is visible as a request in the same cycle the flag is
  // being raised, so the arbiter can grant exactly REFRESH_CYCLES cycles in.
  assign o_req = r_pending | w_tick;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
      // A new interval expiring outranks a clear: that is a fresh refresh due.
      if (w_tick) begin
        r_pending <= 1'b1;
      end else if (i_clr) begin
        r_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates refresh, video reads and CPU accesses onto one SDRAM controller port.
// Latency: 3 cycles REQ-to-ACK with immediate MEM_READY/MEM_DONE; one transaction in flight.
// Backpressure: MEM_* held stable in ISSUE until MEM_READY; requesters hold REQ until ACK.
// Ports: CLK_SDRAM/nRESET; VID_* video read port; CPU_* read/write port;
//        MEM_* command/response port to the SDRAM controller.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 24,
  parameter int REFRESH_CYCLES = 390,
  parameter int VID_MAX        = 4
) (
  input  logic              CLK_SDRAM,
  input  logic              nRESET,
  input  logic              VID_REQ,
  input  logic [ADDR_W-1:0] VID_ADDR,
  output logic              VID_ACK,
  output logic [15:0]       VID_RDATA,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [15:0]       CPU_WDATA,
  input  logic [1:0]        CPU_BE,
  output logic              CPU_ACK,
  output logic [15:0]       CPU_RDATA,
  output logic              MEM_VALID,
  input  logic              MEM_READY,
  output logic [1:0]        MEM_OP,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [15:0]       MEM_WDATA,
  output logic [1:0]        MEM_BE,
  input  logic              MEM_DONE,
  input  logic [15:0]       MEM_RDATA
);

  localparam int VCNT_W = (VID_MAX > 0) ? $clog2(VID_MAX + 1) : 1;

  state_e            r_state;
  owner_e            r_owner;
  logic [VCNT_W-1:0] r_vid_cnt;

  logic w_ref_req;
  logic w_ref_clr;
  logic w_ack_cycle;
  logic w_vid_capped;
  logic w_grant_ref;
  logic w_grant_vid;
  logic w_grant_cpu;

  sdram_refresh_timer #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_refresh_timer (
    .i_clk   (CLK_SDRAM),
    .i_rst_n (nRESET),
    .i_clr   (w_ref_clr),
    .o_req   (w_ref_req)
  );

  assign w_ref_clr = (r_state == ISSUE) && (r_owner == OWN_REF) && MEM_READY;

  always_comb begin
    // While an ACK is on the wire the requester has not yet had a chance to drop
    // REQ, so arbitration waits one cycle to avoid granting it twice.
    w_ack_cycle  = VID_ACK | CPU_ACK;
    w_vid_capped = CPU_REQ && (r_vid_cnt == VCNT_W'(VID_MAX));
    w_grant_ref  = (r_state == IDLE) && !w_ack_cycle && w_ref_req;
    w_grant_vid  = (r_state == IDLE) && !w_ack_cycle && !w_ref_req &&
                   VID_REQ && !w_vid_capped;
    w_grant_cpu  = (r_state == IDLE) && !w_ack_cycle && !w_ref_req &&
                   CPU_REQ && !(VID_REQ && !w_vid_capped);
  end

  always_ff @(posedge CLK_SDRAM or negedge nRESET) begin
    if (!nRESET) begin
      r_state   <= IDLE;
      r_owner   <= OWN_VID;
      r_vid_cnt <= '0;
      MEM_VALID <= 1'b0;
      MEM_OP    <= '0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      MEM_BE    <= '0;
      VID_ACK   <= 1'b0;
      VID_RDATA <= '0;
      CPU_ACK   <= 1'b0;
      CPU_RDATA <= '0;
    end else begin
      VID_ACK <= 1'b0;
      CPU_ACK <= 1'b0;

      // Starvation counter only matters while the CPU is actually waiting.
      if (!CPU_REQ || w_grant_cpu) begin
        r_vid_cnt <= '0;
      end else if (w_grant_vid) begin
        r_vid_cnt <= r_vid_cnt + VCNT_W'(1);
      end

      case (r_state)
        IDLE: begin
          if (w_grant_ref) begin
            r_owner   <= OWN_REF;
            MEM_OP    <= OP_REFRESH;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            MEM_BE    <= '0;
          end else if (w_grant_vid) begin
            r_owner   <= OWN_VID;
            MEM_OP    <= OP_READ;
            MEM_ADDR  <= VID_ADDR;
            MEM_WDATA <= '0;
            MEM_BE    <= '0;
          end else if (w_grant_cpu) begin
            r_owner   <= OWN_CPU;
            MEM_OP    <= CPU_WE ? OP_WRITE : OP_READ;
            MEM_ADDR  <= CPU_ADDR;
            MEM_WDATA <= CPU_WDATA;
            MEM_BE    <= CPU_BE;
          end
          if (w_grant_ref || w_grant_vid || w_grant_cpu) begin
            MEM_VALID <= 1'b1;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (MEM_READY) begin
            MEM_VALID <= 1'b0;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (MEM_DONE) begin
            r_state <= IDLE;
            case (r_owner)
              OWN_VID: begin
                VID_ACK   <= 1'b1;
                VID_RDATA <= MEM_RDATA;
              end
              OWN_CPU: begin
                CPU_ACK   <= 1'b1;
                CPU_RDATA <= MEM_RDATA;
              end
              default: ;  // refresh completes silently
            endcase
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed requests, an SDRAM controller model and a
// scoreboard of expected commands and acknowledgements.
// Latency/backpressure: controller model accepts on MEM_READY and answers after done_delay.
module tb_sdram_arbiter;
  import sdram_arbiter_pkg::*;

  localparam int ADDR_W = 24;

  logic              CLK_SDRAM = 1'b0;
  logic              nRESET    = 1'b0;
  logic              VID_REQ   = 1'b0;
  logic [ADDR_W-1:0] VID_ADDR  = '0;
  logic              VID_ACK;
  logic [15:0]       VID_RDATA;
  logic              CPU_REQ   = 1'b0;
  logic              CPU_WE    = 1'b0;
  logic [ADDR_W-1:0] CPU_ADDR  = '0;
  logic [15:0]       CPU_WDATA = '0;
  logic [1:0]        CPU_BE    = '0;
  logic              CPU_ACK;
  logic [15:0]       CPU_RDATA;
  logic              MEM_VALID;
  logic              MEM_READY = 1'b1;
  logic [1:0]        MEM_OP;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [15:0]       MEM_WDATA;
  logic [1:0]        MEM_BE;
  logic              MEM_DONE  = 1'b0;
  logic [15:0]       MEM_RDATA = '0;

  typedef struct {
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
    logic [1:0]        be;
  } cmd_t;

  typedef struct {
    logic        is_cpu;
    logic [15:0] rdata;
  } ack_t;

  cmd_t exp_cmd_q[$];
  ack_t exp_ack_q[$];

  int          n_checks      = 0;
  int          n_pass        = 0;
  int          done_delay    = 0;
  logic [15:0] mem_rdata_val = 16'h0000;

  sdram_arbiter #(
    .ADDR_W(ADDR_W), .REFRESH_CYCLES(390), .VID_MAX(4)
  ) dut (
    .CLK_SDRAM(CLK_SDRAM), .nRESET(nRESET),
    .VID_REQ(VID_REQ), .VID_ADDR(VID_ADDR), .VID_ACK(VID_ACK), .VID_RDATA(VID_RDATA),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_BE(CPU_BE), .CPU_ACK(CPU_ACK), .CPU_RDATA(CPU_RDATA),
    .MEM_VALID(MEM_VALID), .MEM_READY(MEM_READY), .MEM_OP(MEM_OP), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_BE(MEM_BE), .MEM_DONE(MEM_DONE), .MEM_RDATA(MEM_RDATA)
  );

  initial forever #10 CLK_SDRAM = ~CLK_SDRAM;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                          input logic [15:0] wdata, input logic [1:0] be);
    cmd_t c;
    c.op = op; c.addr = addr; c.wdata = wdata; c.be = be;
    exp_cmd_q.push_back(c);
  endtask

  task automatic push_ack(input logic is_cpu, input logic [15:0] rdata);
    ack_t a;
    a.is_cpu = is_cpu; a.rdata = rdata;
    exp_ack_q.push_back(a);
  endtask

  // Runs until every expected command and ACK has been seen; requesters drop REQ on their ACK.
  task automatic drain(input string name, input int budget);
    int i = 0;
    while ((exp_cmd_q.size() != 0 || exp_ack_q.size() != 0) && i < budget) begin
      @(negedge CLK_SDRAM);
      i++;
      if (VID_ACK) VID_REQ = 1'b0;
      if (CPU_ACK) CPU_REQ = 1'b0;
    end
    if (exp_cmd_q.size() != 0 || exp_ack_q.size() != 0) timeout_fail(name);
    repeat (3) @(negedge CLK_SDRAM);
  endtask

  // SDRAM controller model: records accepted commands against the expected queue,
  // then pulses MEM_DONE done_delay cycles after the accepting edge.
  initial begin : mem_model
    int  wcnt = 0;
    bit  busy = 1'b0;
    cmd_t e;
    forever begin
      @(negedge CLK_SDRAM);
      MEM_DONE = 1'b0;
      if (!nRESET) begin
        busy = 1'b0;
      end else if (busy) begin
        if (wcnt == 0) begin
          MEM_DONE  = 1'b1;
          MEM_RDATA = mem_rdata_val;
          busy      = 1'b0;
        end else begin
          wcnt--;
        end
      end else if (MEM_VALID && MEM_READY) begin
        busy = 1'b1;
        wcnt = done_delay;
        if (exp_cmd_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_cmd: got op=%0d addr=0x%0h, expected no command",
                   MEM_OP, MEM_ADDR);
        end else begin
          e = exp_cmd_q.pop_front();
          chk("cmd_op", 64'(MEM_OP), 64'(e.op));
          chk("cmd_addr", 64'(MEM_ADDR), 64'(e.addr));
          if (e.op == OP_WRITE) begin
            chk("cmd_wdata", 64'(MEM_WDATA), 64'(e.wdata));
            chk("cmd_be", 64'(MEM_BE), 64'(e.be));
          end
        end
      end
    end
  end

  // ACK monitor: every ACK pulse must match the next expected owner and data.
  initial begin : ack_monitor
    ack_t a;
    forever begin
      @(negedge CLK_SDRAM);
      if (VID_ACK || CPU_ACK) begin
        if (VID_ACK && CPU_ACK) begin
          n_checks++;
          $display("FAIL ack_both: got VID_ACK=1 CPU_ACK=1, expected one at a time");
        end else if (exp_ack_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_ack: got VID_ACK=%0b CPU_ACK=%0b, expected none",
                   VID_ACK, CPU_ACK);
        end else begin
          a = exp_ack_q.pop_front();
          chk("ack_owner_cpu", 64'(CPU_ACK), 64'(a.is_cpu));
          chk("ack_rdata", 64'(CPU_ACK ? CPU_RDATA : VID_RDATA), 64'(a.rdata));
        end
      end
    end
  end

  initial begin : stimulus
    int nc;
    int i;

    // Reset values
    #35;
    chk("rst_mem_valid", 64'(MEM_VALID), 64'd0);
    chk("rst_acks", 64'({VID_ACK, CPU_ACK}), 64'd0);
    chk("rst_mem_fields", 64'({MEM_OP, MEM_ADDR, MEM_WDATA, MEM_BE}), 64'd0);
    chk("rst_rdata", 64'({VID_RDATA, CPU_RDATA}), 64'd0);

    // First refresh exactly 390 cycles after release
    push_cmd(OP_REFRESH, '0, '0, '0);
    @(negedge CLK_SDRAM);
    nRESET = 1'b1;
    repeat (389) @(posedge CLK_SDRAM);
    #1 chk("refresh_not_early", 64'(MEM_VALID), 64'd0);
    @(posedge CLK_SDRAM);
    #1 chk("refresh_at_390", 64'({MEM_VALID, MEM_OP}), 64'({1'b1, OP_REFRESH}));
    drain("refresh_first", 20);

    // CPU write, 3-cycle latency
    mem_rdata_val = 16'h1111;
    push_cmd(OP_WRITE, 24'h000123, 16'hBEEF, 2'b01);
    push_ack(1'b1, 16'h1111);
    CPU_WE = 1'b1; CPU_ADDR = 24'h000123; CPU_WDATA = 16'hBEEF; CPU_BE = 2'b01;
    CPU_REQ = 1'b1;
    repeat (2) @(posedge CLK_SDRAM);
    #1 chk("cpu_ack_not_early", 64'(CPU_ACK), 64'd0);
    @(posedge CLK_SDRAM);
    #1 chk("cpu_ack_at_3", 64'(CPU_ACK), 64'd1);
    @(negedge CLK_SDRAM);
    CPU_REQ = 1'b0;
    drain("cpu_write", 30);

    // Video read
    mem_rdata_val = 16'h5A5A;
    push_cmd(OP_READ, 24'h00ABCD, '0, '0);
    push_ack(1'b0, 16'h5A5A);
    VID_ADDR = 24'h00ABCD;
    VID_REQ  = 1'b1;
    drain("vid_read", 30);
    chk("vid_rdata_held", 64'(VID_RDATA), 64'h5A5A);

    // Starvation bound: V,V,V,V,C,V,V,V,V,C
    mem_rdata_val = 16'h0F0F;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) begin
        push_cmd(OP_READ, 24'h000C00, '0, '0);
        push_ack(1'b1, 16'h0F0F);
      end else begin
        push_cmd(OP_READ, 24'h000B00, '0, '0);
        push_ack(1'b0, 16'h0F0F);
      end
    end
    VID_ADDR = 24'h000B00;
    CPU_ADDR = 24'h000C00; CPU_WE = 1'b0;
    VID_REQ = 1'b1; CPU_REQ = 1'b1;
    nc = 0; i = 0;
    while (nc < 2 && i < 300) begin
      @(negedge CLK_SDRAM);
      i++;
      if (CPU_ACK) nc++;
    end
    VID_REQ = 1'b0; CPU_REQ = 1'b0;
    if (nc < 2) timeout_fail("starvation_cpu_acks");
    drain("starvation", 50);

    // MEM_READY low for 10 cycles: command must stay stable
    mem_rdata_val = 16'hC3C3;
    @(posedge CLK_SDRAM);
    #1 MEM_READY = 1'b0;
    @(negedge CLK_SDRAM);
    push_cmd(OP_WRITE, 24'h000456, 16'h1234, 2'b10);
    push_ack(1'b1, 16'hC3C3);
    CPU_WE = 1'b1; CPU_ADDR = 24'h000456; CPU_WDATA = 16'h1234; CPU_BE = 2'b10;
    CPU_REQ = 1'b1;
    i = 0;
    while (!MEM_VALID && i < 10) begin
      @(negedge CLK_SDRAM);
      i++;
    end
    if (!MEM_VALID) timeout_fail("stall_valid");
    for (int k = 0; k < 10; k++) begin
      chk("stall_stable", 64'({MEM_VALID, MEM_OP, MEM_ADDR, MEM_WDATA, MEM_BE}),
          64'({1'b1, OP_WRITE, 24'h000456, 16'h1234, 2'b10}));
      if (k < 9) @(negedge CLK_SDRAM);
    end
    @(posedge CLK_SDRAM);
    #1 MEM_READY = 1'b1;
    drain("stall", 30);

    // Reset pulsed while in WAIT: everything to 0, no ACK
    done_delay = 20;
    push_cmd(OP_READ, 24'h000777, '0, '0);
    VID_ADDR = 24'h000777;
    VID_REQ  = 1'b1;
    i = 0;
    while (exp_cmd_q.size() != 0 && i < 20) begin
      @(negedge CLK_SDRAM);
      i++;
    end
    if (exp_cmd_q.size() != 0) timeout_fail("rst_wait_accept");
    @(negedge CLK_SDRAM);
    nRESET = 1'b0;
    VID_REQ = 1'b0;
    #1;
    chk("midrst_mem_valid", 64'(MEM_VALID), 64'd0);
    chk("midrst_acks", 64'({VID_ACK, CPU_ACK}), 64'd0);
    chk("midrst_mem_fields", 64'({MEM_OP, MEM_ADDR, MEM_WDATA, MEM_BE}), 64'd0);
    chk("midrst_rdata", 64'({VID_RDATA, CPU_RDATA}), 64'd0);
    repeat (3) @(negedge CLK_SDRAM);
    done_delay = 0;
    nRESET = 1'b1;

    // Refresh expires with both REQs pending: REF, then V, then C
    mem_rdata_val = 16'h2222;
    push_cmd(OP_REFRESH, '0, '0, '0);
    push_cmd(OP_READ, 24'h000888, '0, '0);
    push_cmd(OP_WRITE, 24'h000999, 16'hCAFE, 2'b11);
    push_ack(1'b0, 16'h2222);
    push_ack(1'b1, 16'h2222);
    repeat (389) @(posedge CLK_SDRAM);
    @(negedge CLK_SDRAM);
    VID_ADDR = 24'h000888;
    CPU_WE = 1'b1; CPU_ADDR = 24'h000999; CPU_WDATA = 16'hCAFE; CPU_BE = 2'b11;
    VID_REQ = 1'b1; CPU_REQ = 1'b1;
    drain("refresh_priority", 60);

    // Two counter wraps during one long WAIT yield a single refresh
    mem_rdata_val = 16'h3333;
    done_delay = 850;
    push_cmd(OP_READ, 24'h000AAA, '0, '0);
    push_cmd(OP_REFRESH, '0, '0, '0);
    push_ack(1'b0, 16'h3333);
    VID_ADDR = 24'h000AAA;
    VID_REQ  = 1'b1;
    i = 0;
    while (exp_cmd_q.size() > 1 && i < 20) begin
      @(negedge CLK_SDRAM);
      i++;
    end
    done_delay = 0;
    drain("refresh_merge", 1200);
    repeat (60) @(negedge CLK_SDRAM);
    chk("end_cmd_queue_empty", 64'(exp_cmd_q.size()), 64'd0);
    chk("end_ack_queue_empty", 64'(exp_ack_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, word-address width.
REQ-002 SHALL have parameter REFRESH_CYCLES, default 390, clock cycles between refresh requests (7.8 us at 50 MHz).
REQ-003 SHALL have parameter VID_MAX, default 4, maximum consecutive video grants while the CPU is waiting.
REQ-004 SHALL have one clock and an asynchronous active-low reset:
- CLK_SDRAM  in  1  sole clock.
- nRESET  in  1  asynchronous, active-low.
REQ-005 SHALL have these video read port signals:
- VID_REQ  in  1  fetch request, held until VID_ACK.
- VID_ADDR  in  ADDR_W  word address.
- VID_ACK  out  1  one-cycle pulse on read completion.
- VID_RDATA  out  16  read data, valid with VID_ACK.
REQ-006 SHALL have these CPU port signals:
- CPU_REQ  in  1  request, held until CPU_ACK.
- CPU_WE  in  1  1=write.
- CPU_ADDR  in  ADDR_W  word address.
- CPU_WDATA  in  16  write data.
- CPU_BE  in  2  byte enables.
- CPU_ACK  out  1  one-cycle completion pulse.
- CPU_RDATA  out  16  read data, valid with CPU_ACK.
REQ-007 SHALL have these SDRAM controller port signals:
- MEM_VALID  out  1  command valid.
- MEM_READY  in  1  command accepted.
- MEM_OP  out  2  00 read, 01 write, 10 refresh.
- MEM_ADDR  out  ADDR_W.
- MEM_WDATA  out  16.
- MEM_BE  out  2.
- MEM_DONE  in  1  completion pulse.
- MEM_RDATA  in  16  valid with MEM_DONE.

Function
REQ-008 SHALL sequence with FSM states IDLE, ISSUE and WAIT, with one transaction outstanding at most.
REQ-009 SHALL raise a sticky refresh_pending flag when the free-running refresh counter reaches REFRESH_CYCLES-1, and SHALL wrap the counter to 0 on the same cycle.
REQ-010 SHALL use this grant priority in IDLE: refresh_pending, then video, then CPU.
REQ-011 SHALL grant the CPU instead of video when CPU_REQ is pending and the consecutive video grant counter equals VID_MAX; refresh still wins over both.
REQ-012 SHALL reset the consecutive video grant counter to 0 on any CPU grant, and SHALL hold it at 0 while CPU_REQ is low.
REQ-013 SHALL, in IDLE with a winner, register the owner, op, address, wdata and BE, and enter ISSUE on the next cycle with MEM_VALID=1.
REQ-014 SHALL hold MEM_VALID and all MEM_* outputs stable in ISSUE until MEM_READY=1, then go to WAIT.
REQ-015 SHALL, in WAIT on MEM_DONE:
- pulse the owner's ACK for exactly one cycle;
- register MEM_RDATA into the owner's RDATA;
- return to IDLE.
REQ-016 SHALL clear refresh_pending when the refresh command is accepted (MEM_VALID & MEM_READY), and SHALL produce no requester ACK for a refresh.
REQ-017 SHALL retain a single pending refresh if the counter wraps while refresh_pending is already set; refreshes are not queued.
REQ-018 SHALL have a minimum latency of 3 cycles from REQ (sampled in IDLE) to ACK when MEM_READY and MEM_DONE each arrive on their first eligible cycle; grant arbitration happens at the earliest in the cycle after ACK.
REQ-019 SHALL ignore MEM_DONE outside WAIT.
REQ-020 SHALL ignore a requester that drops REQ before its ACK; the transaction already granted completes.
REQ-021 SHALL, when a refresh and a CPU request become pending on the same cycle, serve the refresh first and the CPU next, unless video is allowed under REQ-011.

Reset
REQ-022 SHALL, while nRESET=0, asynchronously force:
- state to IDLE;
- MEM_VALID, VID_ACK and CPU_ACK to 0;
- MEM_OP, MEM_ADDR, MEM_WDATA, MEM_BE, VID_RDATA and CPU_RDATA to 0;
- both counters and refresh_pending to 0.
REQ-023 SHALL, when reset is asserted mid-transaction, drop the in-flight transaction with no ACK; the SDRAM controller is reset by the same nRESET.
REQ-024 SHALL make the first refresh request REFRESH_CYCLES cycles after reset release.

Structure
REQ-025 SHALL place the MEM_OP encodings (OP_READ, OP_WRITE, OP_REFRESH) and the owner encoding (OWN_VID, OWN_CPU, OWN_REF) in the shared SDRAM package.
REQ-026 SHALL implement the refresh timer as sub-module sdram_refresh_timer (counter plus sticky pending flag with a clear input); the FSM and arbitration stay in sdram_arbiter.

Verification
REQ-027 Reset and first refresh: release reset with no requests -> MEM_VALID=1 with MEM_OP=10 exactly 390 cycles later; no ACKs.
REQ-028 CPU write: CPU_WE=1, CPU_ADDR=0x000123, CPU_WDATA=0xBEEF, CPU_BE=01, MEM_READY and MEM_DONE immediate -> MEM_OP=01 with matching fields, then one CPU_ACK pulse 3 cycles after the request.
REQ-029 Video read: MEM_RDATA=0x5A5A -> VID_RDATA=0x5A5A with a single VID_ACK pulse; CPU_ACK stays 0.
REQ-030 Starvation bound: VID_REQ and CPU_REQ held high continuously -> grant order V,V,V,V,C,V,V,V,V,C.
REQ-031 Refresh priority: refresh counter expires while both REQs are pending in IDLE -> refresh granted first; then video; counter wrap during WAIT does not produce a second refresh.
REQ-032 MEM_READY held low 10 cycles in ISSUE -> MEM_* stable all 10 cycles; nRESET pulsed in WAIT -> all outputs 0 and no ACK.
